// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data-memory port between the IFU (read-only) and the
// LSU (read/write). One transaction is in flight at a time, sequenced by an
// IDLE -> REQ -> WAIT FSM. Requests use valid/ready handshakes; responses are
// registered one-cycle pulses.
//
// Build option: define ARB_RR_EN for round-robin arbitration on ties. Without it,
// the LSU has fixed priority over the IFU.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MASK_W = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,

  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_t state;
  state_t state_nxt;

  logic   grant_lsu;
  logic   accept;
  logic   resp_take;
  logic   resp_pulse;

  // A response is only honoured while waiting for one.
  assign resp_take  = (state == ST_WAIT) && mem_resp_valid;
  // No new grant in the cycle a response pulse is out: keeps accept-to-accept
  // at four cycles and lets a responding master's new request wait for the next IDLE.
  assign resp_pulse = ifu_resp_valid | lsu_resp_valid;
  assign accept     = ifu_req_ready | lsu_req_ready;

  // Arbitration winner; owner doubles as the last-granted pointer.
  always_comb begin
    grant_lsu = lsu_req_valid;
`ifdef ARB_RR_EN
    if (lsu_req_valid && ifu_req_valid) begin
      grant_lsu = (owner == OWN_IFU);
    end
`else
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State-decoded outputs: combinational ready to the winner, memory request strobe, busy.
  always_comb begin
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    busy          = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (!resp_pulse) begin
          lsu_req_ready = lsu_req_valid && grant_lsu;
          ifu_req_ready = ifu_req_valid && !grant_lsu;
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
      end
      default: begin
        mem_req_valid = 1'b0;
      end
    endcase
  end

  // Latch the accepted request fields and the owning master.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      owner     <= OWN_LSU;
    end else if (lsu_req_ready) begin
      mem_addr  <= lsu_addr;
      mem_wen   <= lsu_wen;
      mem_wdata <= lsu_wdata;
      mem_wmask <= lsu_wmask;
      owner     <= OWN_LSU;
    end else if (ifu_req_ready) begin
      mem_addr  <= ifu_addr;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      owner     <= OWN_IFU;
    end
  end

  // Register the memory response into the owner's one-cycle pulse and read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      lsu_rdata      <= '0;
    end else begin
      ifu_resp_valid <= resp_take && (owner == OWN_IFU);
      lsu_resp_valid <= resp_take && (owner == OWN_LSU);
      if (resp_take) begin
        if (owner == OWN_LSU) begin
          lsu_rdata <= mem_wen ? '0 : mem_rdata;
        end else begin
          ifu_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a response scoreboard.
// Compile with ARB_RR_EN defined to check the round-robin grant order.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        owner;

  typedef struct packed {
    logic        is_lsu;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec;
  int   n_miss;

  mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MASK_W(8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_rdata      (ifu_rdata),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_rdata      (lsu_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .busy           (busy),
    .owner          (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, limit 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents seen by reads.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk_fields(input string tag, input logic [31:0] a, input logic w,
                            input logic [31:0] wd, input logic [7:0] wm);
    check_val({tag, "_addr"},  64'(mem_addr),  64'(a));
    check_val({tag, "_wen"},   64'(mem_wen),   64'(w));
    check_val({tag, "_wdata"}, 64'(mem_wdata), 64'(wd));
    check_val({tag, "_wmask"}, 64'(mem_wmask), 64'(wm));
  endtask

  task automatic chk_reset(input string tag);
    check_val({tag, "_busy"},  64'(busy), 64'd0);
    check_val({tag, "_mreq"},  64'(mem_req_valid), 64'd0);
    check_val({tag, "_ready"}, 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
    check_val({tag, "_resp"},  64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
    check_val({tag, "_ifu_rdata"}, 64'(ifu_rdata), 64'd0);
    check_val({tag, "_lsu_rdata"}, 64'(lsu_rdata), 64'd0);
    check_val({tag, "_owner"}, 64'(owner), 64'd1);
    chk_fields(tag, 32'd0, 1'b0, 32'd0, 8'd0);
  endtask

  // Called at a negedge; waits (bounded) until some ready is visible.
  task automatic wait_grant();
    int n;
    n = 0;
    while (!(ifu_req_ready || lsu_req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("grant_seen", 64'(ifu_req_ready | lsu_req_ready), 64'd1);
  endtask

  // Entered 1 time unit after the accepting edge; leaves at the negedge of the response pulse.
  task automatic serve_mem(input logic exp_lsu, input logic [31:0] a, input logic w,
                           input logic [31:0] wd, input logic [7:0] wm,
                           input logic [31:0] rd, input int stall, input bit stray);
    mem_req_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      mem_resp_valid = stray && (i == 0);
      mem_rdata      = 32'hFEED_F00D;
      @(negedge clk);
      check_val("bp_req_valid", 64'(mem_req_valid), 64'd1);
      chk_fields("bp", a, w, wd, wm);
      check_val("bp_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
      check_val("bp_no_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    @(negedge clk);
    check_val("req_valid", 64'(mem_req_valid), 64'd1);
    check_val("req_busy", 64'(busy), 64'd1);
    chk_fields("req", a, w, wd, wm);
    @(posedge clk); #1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = rd;
    @(negedge clk);
    check_val("wait_req_valid", 64'(mem_req_valid), 64'd0);
    check_val("wait_busy", 64'(busy), 64'd1);
    check_val("wait_no_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'd0;
    @(negedge clk);
    check_val("resp_pulse", 64'({ifu_resp_valid, lsu_resp_valid}), exp_lsu ? 64'd1 : 64'd2);
    check_val("resp_busy", 64'(busy), 64'd0);
    check_val("resp_owner_reg", 64'(owner), 64'(exp_lsu));
  endtask

  // One full transaction from a single master; entered and left at a negedge.
  task automatic run_txn(input logic is_lsu, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input logic [7:0] wm,
                         input int stall, input bit stray);
    exp_t        ex;
    logic [31:0] rd;
    @(posedge clk); #1;
    if (is_lsu) begin
      lsu_req_valid = 1'b1;
      lsu_addr      = a;
      lsu_wen       = w;
      lsu_wdata     = wd;
      lsu_wmask     = wm;
    end else begin
      ifu_req_valid = 1'b1;
      ifu_addr      = a;
    end
    rd        = w ? 32'hBAD0_BAD0 : mem_model(a);
    ex.is_lsu = is_lsu;
    ex.rdata  = w ? 32'd0 : rd;
    sb.push_back(ex);
    @(negedge clk);
    wait_grant();
    check_val("grant", 64'({ifu_req_ready, lsu_req_ready}), is_lsu ? 64'd1 : 64'd2);
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    if (is_lsu) serve_mem(1'b1, a, w, wd, wm, rd, stall, stray);
    else        serve_mem(1'b0, a, 1'b0, 32'd0, 8'd0, rd, stall, stray);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Scoreboard: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && (ifu_resp_valid || lsu_resp_valid)) begin
      if (sb.size() == 0) begin
        check_val("stray_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("sb_owner", 64'({ifu_resp_valid, lsu_resp_valid}), mon_e.is_lsu ? 64'd1 : 64'd2);
        check_val("sb_rdata", 64'(mon_e.is_lsu ? lsu_rdata : ifu_rdata), 64'(mon_e.rdata));
      end
    end
  end

  initial begin
    logic [3:0]  tie_pat;
    logic        exp_l;
    exp_t        ex;
    logic [31:0] ia;
    logic [31:0] la;

    n_vec  = 0;
    n_miss = 0;
    rst            = 1'b0;
    ifu_req_valid  = 1'b0;
    ifu_addr       = 32'd0;
    lsu_req_valid  = 1'b0;
    lsu_addr       = 32'd0;
    lsu_wen        = 1'b0;
    lsu_wdata      = 32'd0;
    lsu_wmask      = 8'd0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("por");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);

    // IFU read alone, then the pulse must be gone a cycle later.
    run_txn(1'b0, 32'h8000_0000, 1'b0, 32'd0, 8'd0, 0, 1'b0);
    @(negedge clk);
    check_val("pulse_one_cycle", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);

    // LSU write, then LSU read under 5 cycles of memory back-pressure.
    run_txn(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F, 0, 1'b0);
    run_txn(1'b1, 32'h8000_2000, 1'b0, 32'h1111_2222, 8'hFF, 5, 1'b0);

    // IFU read with a stray memory response while in REQ; LSU payload is stale garbage.
    run_txn(1'b0, 32'h8000_0040, 1'b0, 32'd0, 8'd0, 2, 1'b1);

    // Stray memory response in IDLE.
    @(posedge clk); #1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h1234_5678;
    @(negedge clk);
    check_val("idle_stray_busy", 64'(busy), 64'd0);
    check_val("idle_stray_mreq", 64'(mem_req_valid), 64'd0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'd0;
    @(negedge clk);
    check_val("idle_stray_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
    check_val("idle_stray_busy2", 64'(busy), 64'd0);

    // Both masters valid for four transactions, from a fresh reset.
    pulse_reset();
    chk_reset("rst_idle");
`ifdef ARB_RR_EN
    tie_pat = 4'b1010;
`else
    tie_pat = 4'b1111;
`endif
    ia = 32'h8000_0100;
    la = 32'h8000_3000;
    @(posedge clk); #1;
    ifu_req_valid = 1'b1;
    ifu_addr      = ia;
    lsu_req_valid = 1'b1;
    lsu_addr      = la;
    lsu_wen       = 1'b0;
    lsu_wdata     = 32'd0;
    lsu_wmask     = 8'd0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_l     = tie_pat[k];
      ex.is_lsu = exp_l;
      ex.rdata  = mem_model(exp_l ? la : ia);
      sb.push_back(ex);
      wait_grant();
      check_val("tie_grant", 64'({ifu_req_ready, lsu_req_ready}), exp_l ? 64'd1 : 64'd2);
      @(posedge clk); #1;
      serve_mem(exp_l, exp_l ? la : ia, 1'b0, 32'd0, 8'd0, mem_model(exp_l ? la : ia), 0, 1'b0);
      check_val("accept_gap", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;

    // Reset while waiting for the memory response; the late response is dropped.
    @(posedge clk); #1;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0200;
    @(negedge clk);
    wait_grant();
    check_val("rw_grant", 64'({ifu_req_ready, lsu_req_ready}), 64'd2);
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    rst           = 1'b0;
    @(negedge clk);
    check_val("rw_in_wait", 64'({busy, mem_req_valid}), 64'd2);
    @(posedge clk); #1;
    rst            = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hCAFE_F00D;
    @(negedge clk);
    chk_reset("rw_reset");
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'd0;
    @(negedge clk);
    check_val("rw_no_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
    check_val("rw_idle", 64'(busy), 64'd0);

    // Recovery after the aborted transaction.
    run_txn(1'b1, 32'h8000_0400, 1'b0, 32'd0, 8'd0, 1, 1'b0);
    @(negedge clk);
    check_val("sb_drain", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the core's single data-memory port between instruction fetch (IFU, read-only) and load/store (LSU, read/write). It sits between the core and the memory model. It serialises one outstanding transaction at a time through a three-state FSM. Requests use a valid/ready handshake and responses are a one-cycle valid pulse.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MASK_W, 8, write byte-mask width (matches memory write mask)

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset (rst=0 at posedge resets)
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  one-cycle pulse, ifu_rdata valid
- ifu_rdata  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1=write, 0=read
- lsu_wdata  in  DATA_W  write data
- lsu_wmask  in  MASK_W  write byte mask
- lsu_resp_valid  out  1  one-cycle pulse, read data or write ack
- lsu_rdata  out  DATA_W  LSU read data; 0 for writes
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/MASK_W  latched request fields
- mem_resp_valid  in  1  memory response (reads and writes)
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  FSM not in IDLE
- owner  out  1  0=IFU, 1=LSU; current or last grant

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: ready goes to the arbitration winner only, combinationally, when that master's valid=1. Handshake completes on valid&ready.
  - On accept, latch addr/wen/wdata/wmask and set owner. IFU requests latch wen=0, wdata=0, wmask=0. Next state is REQ.
- REQ: mem_req_valid=1 with the latched fields, held stable until mem_req_ready=1, then WAIT. Both ready outputs are 0.
- WAIT: mem_req_valid=0. On mem_resp_valid=1, register the response:
  - Next cycle, the owner's resp_valid=1 for exactly one cycle.
  - rdata is mem_rdata, or 0 when wen=1.
  - FSM returns to IDLE in the same cycle the pulse is driven.
- mem_req_ready=1 in the same cycle as entry to WAIT is legal. mem_resp_valid is only honoured in WAIT and ignored in IDLE/REQ.
- Arbitration, fixed mode: LSU wins whenever lsu_req_valid=1.
- Requesters keep valid and payload stable until ready. The arbiter does not check this.
- A master whose response pulse is being driven may raise a new valid that cycle. It is arbitrated in the following IDLE.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: mem_req_valid=0, both req_ready=0, both resp_valid=0, both rdata=0, all mem_* fields=0, busy=0, owner=1.
  - Round-robin pointer: LSU.
- Latency, with memory ready and responding immediately:
  - Accept at cycle N.
  - mem_req_valid at N+1.
  - WAIT at N+2.
  - Response pulse at cycle M+1 after mem_resp_valid at cycle M.
- Minimum 4 cycles from accept to next accept.
- Reset asserted mid-transaction returns to IDLE next cycle. No resp_valid is issued for the aborted transaction, and a late mem_resp_valid is ignored.
- Simultaneous valids in IDLE are resolved by the arbitration mode. The loser's ready stays 0 and its request is not dropped.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - On a tie, grant the master not granted last. The pointer updates on each accept.
  - A lone requester always wins.
  - The first tie after reset goes to IFU.
- ARB_RR_EN undefined: fixed LSU-over-IFU priority. IFU can starve under continuous LSU traffic.

## Test plan
- IFU read alone: ifu_addr=0x80000000, memory returns 0x00000413 one cycle after request accept. Expect ifu_resp_valid pulse with ifu_rdata=0x00000413, lsu_resp_valid=0, and the latency above.
- LSU write: lsu_addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F. Expect mem_wen=1 with exact fields, then lsu_resp_valid pulse with lsu_rdata=0.
- Simultaneous valids held for 4 transactions.
  - Fixed mode: grants LSU,LSU,LSU,LSU.
  - ARB_RR_EN: grants IFU,LSU,IFU,LSU.
- Memory back-pressure: mem_req_ready low for 5 cycles. Expect mem_req_valid and fields stable throughout and both req_ready=0.
- Stray response: mem_resp_valid pulsed in IDLE and in REQ. Expect no resp_valid and no state change.
- Reset in WAIT: drive rst=0 for one cycle, then mem_resp_valid. Expect IDLE, all outputs at reset values, and no resp_valid.
